seq_ctrl: RTL

SEQ_CTRL -- requirements
Module: seq_ctrl

---
 rtl/seq_ctrl_pkg.sv | 42 ++++
 rtl/seq_opclass.sv | 22 ++
 rtl/seq_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/seq_ctrl_pkg.sv
// Shared state encodings, opcode constants and opcode-class bundle
// for the multi-cycle instruction sequencer.
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LOAD  = 6'h23;
    localparam logic [5:0] OP_STORE = 6'h2B;

    localparam int unsigned TO_W = 8;

    typedef struct packed {
        logic is_alu;
        logic is_load;
        logic is_store;
        logic is_branch;
    } opclass_t;

    function automatic logic br_taken(input logic [5:0] op,
                                      input logic       zero);
        return ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
    endfunction

endpackage

// File: rtl/seq_opclass.sv
// Combinational opcode classifier; an all-zero class means the
// opcode is not executable by the sequencer.
module seq_opclass
    import seq_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    output opclass_t   cls_o
);

    always_comb begin
        cls_o = '0;
        case (op_i)
            OP_RTYPE, OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: cls_o.is_alu = 1'b1;
            OP_LOAD:                            cls_o.is_load = 1'b1;
            OP_STORE:                           cls_o.is_store = 1'b1;
            OP_BEQ, OP_BNE:                     cls_o.is_branch = 1'b1;
            default:                            cls_o = '0;
        endcase
    end

endmodule

// File: rtl/seq_ctrl.sv
// Moore instruction sequencer IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP.
// Define SEQ_TIMEOUT_EN to trap on memory acks missing for TO_CYCLES.
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned TO_CYCLES = 16
) (
    input  logic       s_i_clk,
    input  logic       s_i_rst,
    input  logic       s_i_run,
    input  logic [5:0] s_i_opcode,
    input  logic       s_i_dec_valid,
    input  logic       s_i_zero,
    input  logic       s_i_imem_ack,
    input  logic       s_i_dmem_ack,
    output logic       s_o_imem_req,
    output logic       s_o_dec_ce,
    output logic       s_o_alu_ce,
    output logic       s_o_dmem_rd,
    output logic       s_o_dmem_wr,
    output logic       s_o_rf_we,
    output logic       s_o_pc_we,
    output logic       s_o_pc_src,
    output logic [2:0] s_o_state,
    output logic       s_o_err
);

    if (TO_CYCLES < 2 || TO_CYCLES > 255) begin : g_bad_to
        $error("seq_ctrl: TO_CYCLES must be within 2..255");
    end

    state_e   state_q, state_d, done_st;
    opclass_t cls_q, cls_d, dec_cls;
    logic     rdy_q;
    logic     to_hit;
    logic     br_d, st_done;

    logic imem_req_q, dec_ce_q, alu_ce_q, dmem_rd_q, dmem_wr_q;
    logic rf_we_q, pc_we_q, pc_src_q, err_q;
    logic imem_req_d, dec_ce_d, alu_ce_d, dmem_rd_d, dmem_wr_d;
    logic rf_we_d, pc_we_d, pc_src_d, err_d;

    seq_opclass u_opclass (
        .op_i  (s_i_opcode),
        .cls_o (dec_cls)
    );

    assign done_st = s_i_run ? ST_FETCH : ST_IDLE;

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        unique case (state_q)
            ST_IDLE: begin
                if (s_i_run && rdy_q) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (s_i_imem_ack) state_d = ST_DECODE;
                else if (to_hit)  state_d = ST_TRAP;
            end
            ST_DECODE: begin
                cls_d = dec_cls;
                if (s_i_dec_valid && (dec_cls != '0)) state_d = ST_EXEC;
                else                                  state_d = ST_TRAP;
            end
            ST_EXEC: begin
                if (cls_q.is_load || cls_q.is_store) state_d = ST_MEM;
                else if (cls_q.is_branch)            state_d = done_st;
                else if (cls_q.is_alu)               state_d = ST_WB;
                else                                 state_d = ST_TRAP;
            end
            ST_MEM: begin
                if (s_i_dmem_ack) state_d = cls_q.is_load ? ST_WB : done_st;
                else if (to_hit)  state_d = ST_TRAP;
            end
            ST_WB:   state_d = done_st;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase
    end

    // Branch outcome is captured on the edge entering EXEC so pc_src is
    // a registered output valid for the whole EXEC cycle.
    always_comb begin
        imem_req_d = (state_d == ST_FETCH);
        dec_ce_d   = (state_d == ST_DECODE);
        alu_ce_d   = (state_d == ST_EXEC);
        dmem_rd_d  = (state_d == ST_MEM) && cls_d.is_load;
        dmem_wr_d  = (state_d == ST_MEM) && cls_d.is_store;
        rf_we_d    = (state_d == ST_WB);
        br_d       = (state_d == ST_EXEC) && cls_d.is_branch;
        st_done    = (state_q == ST_MEM) && cls_q.is_store && s_i_dmem_ack;
        pc_we_d    = br_d || rf_we_d || st_done;
        pc_src_d   = br_d && br_taken(s_i_opcode, s_i_zero);
        err_d      = err_q || (state_d == ST_TRAP);
    end

    always_ff @(posedge s_i_clk) begin
        if (s_i_rst) begin
            state_q    <= ST_IDLE;
            cls_q      <= '0;
            rdy_q      <= 1'b0;
            imem_req_q <= 1'b0;
            dec_ce_q   <= 1'b0;
            alu_ce_q   <= 1'b0;
            dmem_rd_q  <= 1'b0;
            dmem_wr_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            pc_we_q    <= 1'b0;
            pc_src_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            rdy_q      <= 1'b1;
            imem_req_q <= imem_req_d;
            dec_ce_q   <= dec_ce_d;
            alu_ce_q   <= alu_ce_d;
            dmem_rd_q  <= dmem_rd_d;
            dmem_wr_q  <= dmem_wr_d;
            rf_we_q    <= rf_we_d;
            pc_we_q    <= pc_we_d;
            pc_src_q   <= pc_src_d;
            err_q      <= err_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            waiting;

    always_comb begin
        waiting = ((state_q == ST_FETCH) && !s_i_imem_ack) ||
                  ((state_q == ST_MEM) && !s_i_dmem_ack);
        cnt_d   = (waiting && (state_d == state_q)) ? cnt_q + 8'd1 : '0;
    end

    always_ff @(posedge s_i_clk) begin
        if (s_i_rst) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign to_hit = (cnt_q == TO_LAST);
`else
    assign to_hit = 1'b0;
`endif

    assign s_o_imem_req = imem_req_q;
    assign s_o_dec_ce   = dec_ce_q;
    assign s_o_alu_ce   = alu_ce_q;
    assign s_o_dmem_rd  = dmem_rd_q;
    assign s_o_dmem_wr  = dmem_wr_q;
    assign s_o_rf_we    = rf_we_q;
    assign s_o_pc_we    = pc_we_q;
    assign s_o_pc_src   = pc_src_q;
    assign s_o_state    = state_q;
    assign s_o_err      = err_q;

endmodule
